decode_addr_gen: RTL
====================

Name: decode_addr_gen

Overview:
- Parametrised successor to the decode stage's read-address generator.
- Accepts a fetched address over a valid/ready handshake and registers two read addresses for the register file: rd_a, the address itself or the address plus STEP; and rd_b, from a sequential auto-increment counter that wraps at DEPTH.
- Sits between the data-out flip-flop stage and the register-file read port.
- Provides one-entry pipeline buffering with backpressure.

Parameters:
- AW, 8: address width in bits.
- DEPTH, 256: modulus of the B counter. Legal range 2 to 2^AW.
- STEP, 1: increment applied by sel_a and sel_b. Legal range 1 to 2^AW-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  in_addr and selects are valid
- in_ready  out  1  block can accept a transfer this cycle
- in_addr  in  AW  fetched address
- sel_a  in  1  0: rd_a = in_addr; 1: rd_a = in_addr + STEP
- sel_b  in  1  0: rd_b = cnt_b; 1: rd_b = (cnt_b + STEP) mod DEPTH
- clr_b  in  1  synchronous clear of the B counter
- out_valid  out  1  rd_a, rd_b, wrap_b and addr_err are valid
- out_ready  in  1  consumer accepts the output
- rd_a  out  AW  register A read address
- rd_b  out  AW  register B read address
- wrap_b  out  1  this output's transfer wrapped cnt_b
- addr_err  out  1  range flag (see Optional Feature)

Behaviour:
- Reset (rst=1, asynchronous): out_valid=0, rd_a=0, rd_b=0, wrap_b=0, addr_err=0, cnt_b=0. The FSM goes to EMPTY. Reset mid-transfer discards the held entry; no output handshake completes.
- FSM states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Handshake signals:
  - in_ready = !out_valid || out_ready. This is combinational from state and out_ready only, never from in_valid.
  - acc = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Transitions:
  - EMPTY, acc -> FULL.
  - FULL, pop && !acc -> EMPTY.
  - FULL, pop && acc -> FULL, loaded with the new entry. This gives back-to-back throughput of 1 per cycle.
  - FULL, !pop -> FULL. rd_a, rd_b, wrap_b and addr_err are held stable.
- Latency: 1 cycle. An accept at edge N presents output from edge N+1.
- On acc, the following load at the same edge:
  - rd_a <= sel_a ? (in_addr + STEP) mod 2^AW : in_addr.
  - rd_b <= sel_b ? (cnt_b + STEP) mod DEPTH : cnt_b.
  - wrap_b <= (cnt_b == DEPTH-1).
  - cnt_b <= (cnt_b == DEPTH-1) ? 0 : cnt_b + 1.
- Arithmetic is unsigned. All sums are computed at AW+1 bits before the modulo, so there is no silent truncation. When DEPTH is not a power of two, compare and subtract explicitly; do not use bit masking.
- cnt_b advances only on acc. Stalls and idle cycles leave it unchanged.
- clr_b:
  - Next cnt_b = 0. clr_b has priority over the increment.
  - If clr_b and acc occur together, the accepted entry uses the pre-clear cnt_b.
  - clr_b does not affect out_valid or the held outputs.
- rd_b reflects the counter value captured at accept time, not the live cnt_b.
- No combinational path from in_* to rd_*. Outputs are registered only.

Optional Feature:
- Macro: DECODE_ADDR_RANGE_CHK_EN
- Defined:
  - On acc, addr_err <= (sel_a && in_addr + STEP >= 2^AW) || (sel_b && cnt_b + STEP >= DEPTH). The flag marks a wrapped address.
  - addr_err is held with the entry, like rd_a and rd_b.
- Undefined: addr_err is tied to 0 and no comparison logic is generated.

Decomposition:
- Shared package decode_pkg:
  - localparam DECODE_AW_DEF = 8.
  - Enum state_e {EMPTY, FULL}.
  - Function wrap_add(value, step, modulus), returning the AW-bit result.
- One sub-module: decode_wrap_cnt.
  - Parameters AW and DEPTH.
  - Ports: clk, rst, inc, clr, cnt, at_max.
  - Implements cnt_b with clr priority.

Test Plan:
- Reset and basic accept:
  - Stimulus: after rst, in_addr=0x05, sel_a=1, sel_b=0, out_ready=1.
  - Response: next cycle out_valid=1, rd_a=0x06, rd_b=0x00, wrap_b=0; cnt_b=1.
- Wrap with DEPTH=5:
  - Stimulus: 6 back-to-back accepts with sel_b=0.
  - Response: rd_b sequence 0,1,2,3,4,0; wrap_b=1 only on the 5th output; sel_b=1 at cnt_b=4 gives rd_b=0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while in_valid=1.
  - Response: in_ready=0 after the first accept; rd_a and rd_b stable; cnt_b does not advance; on release, one pop and one accept in the same cycle.
- clr_b with accept:
  - Stimulus: cnt_b=3, clr_b=1 in the same cycle as acc.
  - Response: that entry has rd_b=3; the next accept has rd_b=0.
- A-wrap, AW=8:
  - Stimulus: in_addr=0xFF, sel_a=1.
  - Response: rd_a=0x00; with DECODE_ADDR_RANGE_CHK_EN, addr_err=1, otherwise addr_err=0.
- Async reset while FULL:
  - Stimulus: assert rst between clock edges while out_valid=1.
  - Response: out_valid, rd_a, rd_b and cnt_b clear immediately; in_ready=1 after release.

Source files
------------

// File: rtl/decode_addr_gen_pkg.sv
// rtl/decode_addr_gen_pkg.sv - shared types, widths and wrap arithmetic for the decode address generator
package decode_pkg;

    localparam int DECODE_AW_DEF = 8;

    // Wide enough for any AW-bit operand plus one carry bit.
    localparam int DECODE_WIDE_W = 33;
    typedef logic [DECODE_WIDE_W-1:0] wide_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Caller guarantees value < modulus and step < modulus, so one subtract suffices.
    function automatic wide_t wrap_add(input wide_t value, input wide_t step, input wide_t modulus);
        wide_t sum;
        sum = value + step;
        return (sum >= modulus) ? (sum - modulus) : sum;
    endfunction

endpackage

// File: rtl/decode_addr_gen_if.sv
// rtl/decode_addr_gen_if.sv - fetch-side and register-file-side handshake bundle
interface decode_addr_gen_if import decode_pkg::*; #(
    parameter int AW = DECODE_AW_DEF
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          sel_a;
    logic          sel_b;
    logic          clr_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] rd_b;
    logic          wrap_b;
    logic          addr_err;

    modport master (
        output in_valid, in_addr, sel_a, sel_b, clr_b, out_ready,
        input  in_ready, out_valid, rd_a, rd_b, wrap_b, addr_err
    );

    modport slave (
        input  in_valid, in_addr, sel_a, sel_b, clr_b, out_ready,
        output in_ready, out_valid, rd_a, rd_b, wrap_b, addr_err
    );
endinterface

// File: rtl/decode_wrap_cnt.sv
// rtl/decode_wrap_cnt.sv - modulo-DEPTH auto-increment counter with clear priority
module decode_wrap_cnt #(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] cnt,
    output logic          at_max
);
    localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    assign at_max = (cnt_q == CNT_MAX);
    assign cnt    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/decode_addr_gen.sv
// rtl/decode_addr_gen.sv - one-entry buffered read-address generator; range flag under DECODE_ADDR_RANGE_CHK_EN
module decode_addr_gen import decode_pkg::*; #(
    parameter int AW    = DECODE_AW_DEF,
    parameter int DEPTH = 256,
    parameter int STEP  = 1
) (
    input  logic                clk,
    input  logic                rst,
    decode_addr_gen_if.slave    bus
);
    localparam wide_t MOD_A  = wide_t'(1) << AW;
    localparam wide_t MOD_B  = wide_t'(DEPTH);
    localparam wide_t STEP_A = wide_t'(STEP);
    // STEP may exceed DEPTH; reducing it once here keeps the runtime wrap to a single subtract.
    localparam wide_t STEP_B = wide_t'(STEP % DEPTH);

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] rd_a_q;
    logic [AW-1:0] rd_a_d;
    logic [AW-1:0] rd_b_q;
    logic [AW-1:0] rd_b_d;
    logic          wrap_q;
    logic          wrap_d;

    logic          in_ready;
    logic          acc;
    logic          pop;
    logic [AW-1:0] cnt_b;
    logic          cnt_at_max;

    assign in_ready = (state_q == EMPTY) || bus.out_ready;
    assign acc      = bus.in_valid && in_ready;
    assign pop      = (state_q == FULL) && bus.out_ready;

    decode_wrap_cnt #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_cnt_b (
        .clk    (clk),
        .rst    (rst),
        .inc    (acc),
        .clr    (bus.clr_b),
        .cnt    (cnt_b),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_d = state_q;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        wrap_d  = wrap_q;

        case (state_q)
            EMPTY:   if (acc) state_d = FULL;
            FULL:    if (pop && !acc) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        // The entry captures the pre-clear counter even when clr_b coincides.
        if (acc) begin
            rd_a_d = bus.sel_a ? AW'(wrap_add(wide_t'(bus.in_addr), STEP_A, MOD_A)) : bus.in_addr;
            rd_b_d = bus.sel_b ? AW'(wrap_add(wide_t'(cnt_b), STEP_B, MOD_B)) : cnt_b;
            wrap_d = cnt_at_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef DECODE_ADDR_RANGE_CHK_EN
    logic  err_q;
    logic  err_d;
    wide_t sum_a;
    wide_t sum_b;

    always_comb begin
        err_d = err_q;
        sum_a = wide_t'(bus.in_addr) + STEP_A;
        sum_b = wide_t'(cnt_b) + wide_t'(STEP);
        if (acc) begin
            err_d = (bus.sel_a && (sum_a >= MOD_A)) || (bus.sel_b && (sum_b >= MOD_B));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.addr_err = err_q;
`else
    assign bus.addr_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.rd_a      = rd_a_q;
    assign bus.rd_b      = rd_b_q;
    assign bus.wrap_b    = wrap_q;
endmodule
